// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle ALU.
// One transaction in flight at a time: grant, issue for one cycle, wait out the ALU latency, respond.
module alu_arbiter #(
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int LAT     = 1,
  parameter int MUL_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        REQ_VALID,
  output logic [1:0]        REQ_READY,
  input  logic [2*DW-1:0]   REQ_OPA,
  input  logic [2*DW-1:0]   REQ_OPB,
  input  logic [2*CW-1:0]   REQ_CMD,
  input  logic [1:0]        REQ_MODE,
  input  logic [1:0]        REQ_CIN,
  output logic [DW-1:0]     ALU_OPA,
  output logic [DW-1:0]     ALU_OPB,
  output logic [CW-1:0]     ALU_CMD,
  output logic              ALU_MODE,
  output logic              ALU_CIN,
  output logic              ALU_CE,
  output logic [1:0]        ALU_INP_VALID,
  input  logic [2*DW-1:0]   ALU_RES,
  input  logic [5:0]        ALU_FLAGS,
  output logic [1:0]        RSP_VALID,
  output logic [2*DW-1:0]   RSP_RES,
  output logic [5:0]        RSP_FLAGS,
  output logic              BUSY
);

  localparam int MAX_LAT = (MUL_LAT > LAT) ? MUL_LAT : LAT;
  localparam int CNTW    = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNTW-1:0] LAT_LOAD  = CNTW'(LAT - 1);
  localparam logic [CNTW-1:0] MUL_LOAD  = CNTW'(MUL_LAT - 1);
  localparam logic [CW-1:0]   CMD_MUL_A = CW'(9);
  localparam logic [CW-1:0]   CMD_MUL_B = CW'(10);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic              ptr;
  logic              idx_q;
  logic [DW-1:0]     opa_q;
  logic [DW-1:0]     opb_q;
  logic [CW-1:0]     cmd_q;
  logic              mode_q;
  logic              cin_q;
  logic [CNTW-1:0]   cnt;
  logic [2*DW-1:0]   rsp_res_q;
  logic [5:0]        rsp_flags_q;
  logic [1:0]        grant;
  logic              handshake;
  logic              grant_idx;
  logic              is_mul;
  logic              cnt_zero;

  // Contention goes to the requester named by ptr; a lone requester always wins.
  always_comb begin
    // NOTE: default assigned first so no path leaves grant unassigned, which would infer a latch.
    grant = 2'b00;
    case (REQ_VALID)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign REQ_READY = (state == IDLE) ? grant : 2'b00;
  assign handshake = |(REQ_VALID & REQ_READY);
  assign grant_idx = REQ_READY[1];
  assign is_mul    = mode_q && ((cmd_q == CMD_MUL_A) || (cmd_q == CMD_MUL_B));
  assign cnt_zero  = (cnt == '0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt_zero) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: datapath registers are reset too, because the ALU-facing outputs must read zero out of reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr         <= 1'b0;
      idx_q       <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      cmd_q       <= '0;
      mode_q      <= 1'b0;
      cin_q       <= 1'b0;
      cnt         <= '0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      if (handshake) begin
        ptr    <= ~grant_idx;
        idx_q  <= grant_idx;
        opa_q  <= grant_idx ? REQ_OPA[2*DW-1:DW] : REQ_OPA[DW-1:0];
        opb_q  <= grant_idx ? REQ_OPB[2*DW-1:DW] : REQ_OPB[DW-1:0];
        cmd_q  <= grant_idx ? REQ_CMD[2*CW-1:CW] : REQ_CMD[CW-1:0];
        mode_q <= REQ_MODE[grant_idx];
        cin_q  <= REQ_CIN[grant_idx];
      end
      // Counter holds remaining WAIT cycles minus one; zero marks the capture edge.
      if (state == ISSUE) begin
        cnt <= is_mul ? MUL_LOAD : LAT_LOAD;
      end else if ((state == WAIT) && !cnt_zero) begin
        cnt <= cnt - CNTW'(1);
      end
      if ((state == WAIT) && cnt_zero) begin
        rsp_res_q   <= ALU_RES;
        rsp_flags_q <= ALU_FLAGS;
      end
    end
  end

  assign ALU_OPA       = opa_q;
  assign ALU_OPB       = opb_q;
  assign ALU_CMD       = cmd_q;
  assign ALU_MODE      = mode_q;
  assign ALU_CIN       = cin_q;
  assign ALU_CE        = (state == ISSUE);
  assign ALU_INP_VALID = {2{ALU_CE}};
  assign RSP_VALID     = (state == RESP) ? (idx_q ? 2'b10 : 2'b01) : 2'b00;
  assign RSP_RES       = rsp_res_q;
  assign RSP_FLAGS     = rsp_flags_q;
  assign BUSY          = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: latency-accurate ALU stand-in plus a transaction-level reference
// (grant order, response cycle, expected result) compared against the DUT every sampled cycle.
module tb_alu_arbiter;

  localparam int DW      = 8;
  localparam int CW      = 4;
  localparam int LAT     = 1;
  localparam int MUL_LAT = 2;
  localparam int RW      = 2 * DW;

  logic            CLK;
  logic            RST;
  logic [1:0]      REQ_VALID;
  logic [1:0]      REQ_READY;
  logic [2*DW-1:0] REQ_OPA;
  logic [2*DW-1:0] REQ_OPB;
  logic [2*CW-1:0] REQ_CMD;
  logic [1:0]      REQ_MODE;
  logic [1:0]      REQ_CIN;
  logic [DW-1:0]   ALU_OPA;
  logic [DW-1:0]   ALU_OPB;
  logic [CW-1:0]   ALU_CMD;
  logic            ALU_MODE;
  logic            ALU_CIN;
  logic            ALU_CE;
  logic [1:0]      ALU_INP_VALID;
  logic [RW-1:0]   ALU_RES;
  logic [5:0]      ALU_FLAGS;
  logic [1:0]      RSP_VALID;
  logic [RW-1:0]   RSP_RES;
  logic [5:0]      RSP_FLAGS;
  logic            BUSY;

  alu_arbiter #(.DW(DW), .CW(CW), .LAT(LAT), .MUL_LAT(MUL_LAT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CMD(REQ_CMD),
    .REQ_MODE(REQ_MODE), .REQ_CIN(REQ_CIN),
    .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_CMD(ALU_CMD),
    .ALU_MODE(ALU_MODE), .ALU_CIN(ALU_CIN), .ALU_CE(ALU_CE),
    .ALU_INP_VALID(ALU_INP_VALID),
    .ALU_RES(ALU_RES), .ALU_FLAGS(ALU_FLAGS),
    .RSP_VALID(RSP_VALID), .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int passed = 0;
  int total  = 0;

  // ALU behaviour used by the stand-in and by the expected-result model.
  function automatic logic [RW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [CW-1:0] c, input logic m, input logic ci);
    logic [RW-1:0] r;
    if (m) begin
      case (c)
        4'd0:       r = RW'(a) + RW'(b) + RW'(ci);
        4'd1:       r = RW'(a) - RW'(b) - RW'(ci);
        4'd9, 4'd10: r = RW'(a) * RW'(b);
        default:    r = {a, b};
      endcase
    end else begin
      r = {a & b, a ^ b};
    end
    return r;
  endfunction

  function automatic logic [5:0] flags_fn(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic ci);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, ci};
    return {s[DW], 1'b0, 1'b0, a > b, a == b, a < b};
  endfunction

  function automatic int lat_of(input logic m, input logic [CW-1:0] c);
    return (m && (c == 4'd9 || c == 4'd10)) ? MUL_LAT : LAT;
  endfunction

  function automatic logic [1:0] arb(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  function automatic logic [CW-1:0] rand_cmd();
    case ($urandom_range(0, 5))
      0:       return 4'd0;
      1:       return 4'd1;
      2:       return 4'd9;
      3:       return 4'd10;
      4:       return 4'd3;
      default: return 4'd7;
    endcase
  endfunction

  // ALU stand-in: result valid exactly L cycles after the issue cycle, noise otherwise.
  int            alu_due = -100;
  logic [RW-1:0] alu_res_q;
  logic [5:0]    alu_flg_q;
  always @(negedge CLK) begin
    if (cyc == alu_due) begin
      ALU_RES   = alu_res_q;
      ALU_FLAGS = alu_flg_q;
    end else begin
      ALU_RES   = RW'($urandom);
      ALU_FLAGS = 6'($urandom);
    end
    if (ALU_CE === 1'b1 && ALU_INP_VALID === 2'b11) begin
      alu_due   = cyc + lat_of(ALU_MODE, ALU_CMD);
      alu_res_q = alu_fn(ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN);
      alu_flg_q = flags_fn(ALU_OPA, ALU_OPB, ALU_CIN);
    end
  end

  // Transaction-level reference: a handshake in cycle k books the unit until k+3+L.
  int            m_free = 0, m_k = -100, m_rsp = -100;
  logic          m_ptr, m_idx, m_mode, m_cin;
  logic [DW-1:0] m_opa, m_opb;
  logic [CW-1:0] m_cmd;
  logic [RW-1:0] m_res;
  logic [5:0]    m_flg;
  logic [1:0]    exp_ready, exp_rsp_valid;
  logic          exp_busy, exp_ce, exp_mode, exp_cin;
  logic [DW-1:0] exp_opa, exp_opb;
  logic [CW-1:0] exp_cmd;
  logic [RW-1:0] exp_res;
  logic [5:0]    exp_flags;

  always @(negedge CLK) begin
    int g;
    int l;
    if (!RST) begin
      m_ptr = 1'b0; m_free = 0; m_k = -100; m_rsp = -100; m_idx = 1'b0;
      m_opa = '0; m_opb = '0; m_cmd = '0; m_mode = 1'b0; m_cin = 1'b0;
      m_res = '0; m_flg = '0; exp_res = '0; exp_flags = '0;
    end else if (cyc == m_rsp) begin
      exp_res   = m_res;
      exp_flags = m_flg;
    end
    exp_busy      = (cyc < m_free);
    exp_ready     = (cyc >= m_free) ? arb(REQ_VALID, m_ptr) : 2'b00;
    exp_ce        = (cyc == m_k + 1);
    exp_rsp_valid = (cyc == m_rsp) ? (m_idx ? 2'b10 : 2'b01) : 2'b00;
    exp_opa = m_opa; exp_opb = m_opb; exp_cmd = m_cmd; exp_mode = m_mode; exp_cin = m_cin;
    if (RST && (REQ_VALID & exp_ready) != 2'b00) begin
      g      = exp_ready[1] ? 1 : 0;
      m_idx  = exp_ready[1];
      m_ptr  = ~exp_ready[1];
      m_opa  = REQ_OPA[g*DW +: DW];
      m_opb  = REQ_OPB[g*DW +: DW];
      m_cmd  = REQ_CMD[g*CW +: CW];
      m_mode = REQ_MODE[g];
      m_cin  = REQ_CIN[g];
      m_res  = alu_fn(m_opa, m_opb, m_cmd, m_mode, m_cin);
      m_flg  = flags_fn(m_opa, m_opb, m_cin);
      l      = lat_of(m_mode, m_cmd);
      m_k    = cyc;
      m_rsp  = cyc + 2 + l;
      m_free = cyc + 3 + l;
    end
  end

  task automatic wait_drive();
    @(posedge CLK); #1;
  endtask

  task automatic wait_sample();
    @(negedge CLK); #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && cyc < m_free; i++) wait_drive();
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [CW-1:0] c, input logic m, input logic ci);
    REQ_OPA[i*DW +: DW] = a;
    REQ_OPB[i*DW +: DW] = b;
    REQ_CMD[i*CW +: CW] = c;
    REQ_MODE[i]         = m;
    REQ_CIN[i]          = ci;
  endtask

  task automatic rand_req(input int i);
    set_req(i, DW'($urandom), DW'($urandom), rand_cmd(), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_reset();
    RST = 1'b0; REQ_VALID = 2'b00; REQ_OPA = '0; REQ_OPB = '0; REQ_CMD = '0; REQ_MODE = '0; REQ_CIN = '0;
    wait_sample();
    total++; if (BUSY !== 1'b0) $display("FAIL reset_busy got=%b exp=0", BUSY); else passed++;
    total++; if (RSP_VALID !== 2'b00) $display("FAIL reset_rsp_valid got=%b exp=00", RSP_VALID); else passed++;
    total++; if (RSP_RES !== 16'h0000) $display("FAIL reset_rsp_res got=%h exp=0000", RSP_RES); else passed++;
    total++; if (RSP_FLAGS !== 6'h00) $display("FAIL reset_rsp_flags got=%h exp=00", RSP_FLAGS); else passed++;
    total++; if (ALU_CE !== 1'b0) $display("FAIL reset_alu_ce got=%b exp=0", ALU_CE); else passed++;
    total++; if (ALU_INP_VALID !== 2'b00) $display("FAIL reset_inp_valid got=%b exp=00", ALU_INP_VALID); else passed++;
    total++; if (ALU_OPA !== 8'h00 || ALU_OPB !== 8'h00) $display("FAIL reset_alu_ops got=%h/%h exp=00/00", ALU_OPA, ALU_OPB); else passed++;
    total++; if (ALU_CMD !== 4'h0 || ALU_MODE !== 1'b0 || ALU_CIN !== 1'b0)
      $display("FAIL reset_alu_cmd got=%h/%b/%b exp=0/0/0", ALU_CMD, ALU_MODE, ALU_CIN); else passed++;
    wait_drive();
    RST = 1'b1;
  endtask

  task automatic test_single_add();
    wait_idle();
    set_req(0, 8'h05, 8'h03, 4'd0, 1'b1, 1'b0);
    REQ_VALID = 2'b01;
    wait_sample();
    total++; if (REQ_READY !== 2'b01) $display("FAIL add_ready got=%b exp=01", REQ_READY); else passed++;
    wait_drive();
    REQ_VALID = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      wait_sample();
      total++; if (ALU_CE !== (i == 1)) $display("FAIL add_ce cyc+%0d got=%b", i, ALU_CE); else passed++;
      total++; if (RSP_VALID !== ((i == 3) ? 2'b01 : 2'b00)) $display("FAIL add_rsp_valid cyc+%0d got=%b", i, RSP_VALID); else passed++;
      if (i == 1) begin
        total++; if (ALU_OPA !== 8'h05 || ALU_OPB !== 8'h03) $display("FAIL add_alu_ops got=%h/%h exp=05/03", ALU_OPA, ALU_OPB); else passed++;
      end
      if (i == 3) begin
        total++; if (RSP_RES !== 16'h0008) $display("FAIL add_rsp_res got=%h exp=0008", RSP_RES); else passed++;
      end
      if (i == 4) begin
        total++; if (BUSY !== 1'b0) $display("FAIL add_busy_after got=%b exp=0", BUSY); else passed++;
      end
      wait_drive();
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] pat [4];
    int ng;
    int nr;
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b10;
    ng = 0; nr = 0;
    RST = 1'b0;
    wait_drive();
    wait_drive();
    RST = 1'b1;
    REQ_VALID = 2'b11;
    for (int c = 0; c < 60 && nr < 4; c++) begin
      rand_req(0);
      rand_req(1);
      wait_sample();
      if (REQ_READY !== 2'b00 && ng < 4) begin
        total++; if (REQ_READY !== pat[ng]) $display("FAIL rr_grant #%0d got=%b exp=%b", ng, REQ_READY, pat[ng]); else passed++;
        ng++;
      end
      if (RSP_VALID !== 2'b00) begin
        total++; if (RSP_VALID !== pat[nr]) $display("FAIL rr_rsp_valid #%0d got=%b exp=%b", nr, RSP_VALID, pat[nr]); else passed++;
        total++; if (RSP_RES !== exp_res) $display("FAIL rr_rsp_res #%0d got=%h exp=%h", nr, RSP_RES, exp_res); else passed++;
        nr++;
      end
      wait_drive();
    end
    REQ_VALID = 2'b00;
    total++; if (nr != 4) $display("FAIL rr_timeout responses=%0d exp=4", nr); else passed++;
  endtask

  task automatic test_multiply();
    logic [DW-1:0] a, b;
    a = DW'($urandom); b = DW'($urandom);
    wait_idle();
    set_req(1, a, b, 4'd9, 1'b1, 1'b0);
    REQ_VALID = 2'b10;
    wait_sample();
    total++; if (REQ_READY !== 2'b10) $display("FAIL mul_ready got=%b exp=10", REQ_READY); else passed++;
    wait_drive();
    REQ_VALID = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      wait_sample();
      total++; if (ALU_CE !== (i == 1)) $display("FAIL mul_ce cyc+%0d got=%b", i, ALU_CE); else passed++;
      total++; if (RSP_VALID !== ((i == 4) ? 2'b10 : 2'b00)) $display("FAIL mul_rsp_valid cyc+%0d got=%b", i, RSP_VALID); else passed++;
      if (i == 4) begin
        total++; if (RSP_RES !== RW'(a) * RW'(b)) $display("FAIL mul_rsp_res got=%h exp=%h", RSP_RES, RW'(a) * RW'(b)); else passed++;
      end
      wait_drive();
    end
    a = DW'($urandom); b = DW'($urandom);
    set_req(0, a, b, 4'd1, 1'b1, 1'b1);
    REQ_VALID = 2'b01;
    wait_sample();
    total++; if (REQ_READY !== 2'b01) $display("FAIL mul_next_ready got=%b exp=01", REQ_READY); else passed++;
    wait_drive();
    REQ_VALID = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      wait_sample();
      total++; if (RSP_VALID !== ((i == 3) ? 2'b01 : 2'b00)) $display("FAIL sub_rsp_valid cyc+%0d got=%b", i, RSP_VALID); else passed++;
      if (i == 3) begin
        total++; if (RSP_RES !== RW'(a) - RW'(b) - 16'd1) $display("FAIL sub_rsp_res got=%h exp=%h", RSP_RES, RW'(a) - RW'(b) - 16'd1); else passed++;
      end
      wait_drive();
    end
  endtask

  task automatic test_operand_hold();
    logic [DW-1:0] a, b;
    logic          ci;
    a = DW'($urandom); b = DW'($urandom); ci = 1'($urandom);
    wait_idle();
    set_req(0, a, b, 4'd10, 1'b1, ci);
    REQ_VALID = 2'b01;
    wait_sample();
    wait_drive();
    REQ_VALID = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      rand_req(0);
      rand_req(1);
      wait_sample();
      total++; if (ALU_OPA !== a || ALU_OPB !== b || ALU_CMD !== 4'd10)
        $display("FAIL hold_alu_ops cyc+%0d got=%h/%h/%h exp=%h/%h/a", i, ALU_OPA, ALU_OPB, ALU_CMD, a, b); else passed++;
      if (i == 4) begin
        total++; if (RSP_VALID !== 2'b01) $display("FAIL hold_rsp_valid got=%b exp=01", RSP_VALID); else passed++;
        total++; if (RSP_RES !== RW'(a) * RW'(b)) $display("FAIL hold_rsp_res got=%h exp=%h", RSP_RES, RW'(a) * RW'(b)); else passed++;
      end
      wait_drive();
    end
  endtask

  task automatic test_reset_midway();
    wait_idle();
    set_req(0, DW'($urandom) | 8'h01, DW'($urandom) | 8'h01, 4'd9, 1'b1, 1'b0);
    REQ_VALID = 2'b01;
    wait_sample();
    wait_drive();
    REQ_VALID = 2'b00;
    wait_drive();
    wait_sample();
    RST = 1'b0;
    #1;
    total++; if (BUSY !== 1'b0) $display("FAIL mid_reset_busy got=%b exp=0", BUSY); else passed++;
    total++; if (RSP_RES !== 16'h0000 || RSP_FLAGS !== 6'h00) $display("FAIL mid_reset_rsp got=%h/%h exp=0/0", RSP_RES, RSP_FLAGS); else passed++;
    total++; if (ALU_OPA !== 8'h00 || ALU_INP_VALID !== 2'b00) $display("FAIL mid_reset_alu got=%h/%b exp=00/00", ALU_OPA, ALU_INP_VALID); else passed++;
    for (int i = 0; i < 2; i++) begin
      wait_drive();
      wait_sample();
      total++; if (RSP_VALID !== 2'b00) $display("FAIL mid_reset_rsp_valid got=%b exp=00", RSP_VALID); else passed++;
    end
    wait_drive();
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_sample();
      total++; if (RSP_VALID !== 2'b00 || BUSY !== 1'b0) $display("FAIL post_reset_quiet got=%b/%b exp=00/0", RSP_VALID, BUSY); else passed++;
      wait_drive();
    end
    rand_req(0);
    rand_req(1);
    REQ_VALID = 2'b11;
    wait_sample();
    total++; if (REQ_READY !== 2'b01) $display("FAIL post_reset_ptr got=%b exp=01", REQ_READY); else passed++;
    wait_drive();
    REQ_VALID = 2'b00;
  endtask

  task automatic test_busy_pulse();
    wait_idle();
    set_req(1, DW'($urandom), DW'($urandom), 4'd0, 1'b1, 1'b0);
    REQ_VALID = 2'b10;
    wait_sample();
    total++; if (REQ_READY !== 2'b10) $display("FAIL pulse_first_ready got=%b exp=10", REQ_READY); else passed++;
    wait_drive();
    for (int i = 1; i <= 3; i++) begin
      REQ_VALID = (i % 2 == 1) ? 2'b01 : 2'b00;
      wait_sample();
      total++; if (REQ_READY !== 2'b00 || BUSY !== 1'b1) $display("FAIL pulse_busy_ready cyc+%0d got=%b/%b exp=00/1", i, REQ_READY, BUSY); else passed++;
      wait_drive();
    end
    REQ_VALID = 2'b11;
    wait_sample();
    total++; if (REQ_READY !== 2'b01) $display("FAIL pulse_ptr got=%b exp=01", REQ_READY); else passed++;
    wait_drive();
    REQ_VALID = 2'b00;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      REQ_VALID = 2'($urandom);
      rand_req(0);
      rand_req(1);
      wait_sample();
      total++; if (REQ_READY !== exp_ready) $display("FAIL rnd_ready @%0d got=%b exp=%b", cyc, REQ_READY, exp_ready); else passed++;
      total++; if (BUSY !== exp_busy) $display("FAIL rnd_busy @%0d got=%b exp=%b", cyc, BUSY, exp_busy); else passed++;
      total++; if (ALU_CE !== exp_ce) $display("FAIL rnd_ce @%0d got=%b exp=%b", cyc, ALU_CE, exp_ce); else passed++;
      total++; if (ALU_INP_VALID !== {2{exp_ce}}) $display("FAIL rnd_inp_valid @%0d got=%b exp=%b", cyc, ALU_INP_VALID, {2{exp_ce}}); else passed++;
      total++; if (RSP_VALID !== exp_rsp_valid) $display("FAIL rnd_rsp_valid @%0d got=%b exp=%b", cyc, RSP_VALID, exp_rsp_valid); else passed++;
      total++; if (RSP_RES !== exp_res) $display("FAIL rnd_rsp_res @%0d got=%h exp=%h", cyc, RSP_RES, exp_res); else passed++;
      total++; if (RSP_FLAGS !== exp_flags) $display("FAIL rnd_rsp_flags @%0d got=%h exp=%h", cyc, RSP_FLAGS, exp_flags); else passed++;
      total++; if (ALU_OPA !== exp_opa || ALU_OPB !== exp_opb)
        $display("FAIL rnd_alu_ops @%0d got=%h/%h exp=%h/%h", cyc, ALU_OPA, ALU_OPB, exp_opa, exp_opb); else passed++;
      total++; if (ALU_CMD !== exp_cmd || ALU_MODE !== exp_mode || ALU_CIN !== exp_cin)
        $display("FAIL rnd_alu_cmd @%0d got=%h/%b/%b exp=%h/%b/%b", cyc, ALU_CMD, ALU_MODE, ALU_CIN, exp_cmd, exp_mode, exp_cin); else passed++;
      wait_drive();
    end
    REQ_VALID = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_multiply();
    test_operand_hold();
    test_reset_midway();
    test_busy_pulse();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
